sfp_generic_write_sm: RTL and testbench
=======================================

# sfp_generic_write_sm

Generic register writer for SFP/I2C devices. It is the write-direction counterpart of the SFP generic register read machine. It takes a block of up to 16 bytes plus a starting register address and drives the shared I2C engine one byte write at a time. After each byte it waits a fixed device write-cycle pause, then reports completion or error. It sits between the FMC control logic and the I2C master.

## Interface
Parameters:
- PAUSE_CYCLES, 625000, post-byte write-cycle pause in clk cycles (5 ms @ 125 MHz).
- MAX_BYTES, 16, largest legal burst; fixed by the 128-bit data port.

Ports:
- clk  in  1  125-MHz clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- start_sm  in  1  request; sampled only in IDLE.
- i2c_lines_busy  in  1  I2C engine/bus busy.
- i2c_error  in  1  engine error (NACK/arbitration), valid while a byte is outstanding.
- i2c_wr_done  in  1  one-cycle pulse when the engine finishes a byte write.
- wr_base_addr  in  8  first register address.
- wr_num_bytes  in  5  byte count; legal range 1..16.
- wr_dat  in  128  payload; byte k = wr_dat[8k+7:8k].
- start_write_sfp  out  1  one-cycle pulse that launches one byte write.
- i2c_wr_addr  out  8  register address for the current byte.
- i2c_wr_byte  out  8  data for the current byte.
- sfp_wr_done  out  1  one-cycle pulse when the burst completes successfully.
- error_i2c_chip  out  1  one-cycle pulse on engine error.
- error_bad_len  out  1  one-cycle pulse on illegal wr_num_bytes.
- sm_running  out  1  low only in IDLE.
- CS  out  8  one-hot current state.

## Operation
- One-hot states, by index:
  - IDLE=0
  - LOAD=1
  - START_WR_BYTE=2
  - PAUSE_WR_BYTE=3
  - WAIT=4
  - DONE=5
  - ERROR_I2C=6
  - ERROR_LEN=7
- Transitions:
  - IDLE: start_sm & ~i2c_lines_busy -> LOAD if 1 <= wr_num_bytes <= 16; -> ERROR_LEN if wr_num_bytes is 0 or >16; otherwise stay.
  - LOAD -> START_WR_BYTE. Latches wr_base_addr, wr_num_bytes and wr_dat; clears the byte index k to 0.
  - START_WR_BYTE -> PAUSE_WR_BYTE.
  - PAUSE_WR_BYTE: i2c_error -> ERROR_I2C (error wins over a simultaneous i2c_wr_done); else i2c_wr_done -> WAIT; else stay.
  - WAIT: when the pause counter reaches 0 and i2c_lines_busy is low: -> START_WR_BYTE with k+1 if k+1 < count, else -> DONE. Otherwise stay.
  - DONE, ERROR_I2C, ERROR_LEN -> IDLE unconditionally.
- Address arithmetic: i2c_wr_addr = latched base + k, modulo 256 (0xFF wraps to 0x00).
- Byte select: i2c_wr_byte = latched wr_dat[8k+7:8k].
- Input changes after LOAD have no effect on the burst in progress.
- Outputs are registered and decoded from NS, so each state's outputs are asserted in the first cycle the state is occupied:
  - start_write_sfp in START_WR_BYTE
  - sfp_wr_done in DONE
  - error_i2c_chip in ERROR_I2C
  - error_bad_len in ERROR_LEN
  - sm_running=0 only when NS is IDLE
- The pause counter reloads to PAUSE_CYCLES on entry to WAIT and decrements every WAIT cycle. It never underflows (it holds at 0).
- An error aborts the remaining bytes. There is no retry.

## Timing
- Reset values:
  - CS=8'b0000_0001
  - all pulse outputs 0
  - sm_running 0
  - i2c_wr_addr and i2c_wr_byte 0x00
  - counter PAUSE_CYCLES
  - k=0
- Asserting reset_n low mid-burst aborts immediately. No further start_write_sfp or done pulses are issued.
- start_sm accepted at edge t: CS=LOAD after t+1, start_write_sfp high in the cycle after edge t+2.
- i2c_wr_addr and i2c_wr_byte are stable from the start_write_sfp cycle until the next start_write_sfp.
- Per-byte cost: 1 (START) + engine latency + (PAUSE_CYCLES+1) minimum in WAIT. WAIT is extended while i2c_lines_busy is high.
- The final byte also takes the full pause before DONE, so sfp_wr_done guarantees the device write cycle has completed.

## Structure
- Shared package sfp_i2c_pkg holds:
  - state index constants (shared naming with the read machine)
  - the default PAUSE_CYCLES
  - MAX_BYTES
- One sub-module, sfp_pause_timer: load/decrement/zero-flag counter, width clog2(PAUSE_CYCLES+1). The read machine can reuse it.
- The state machine, byte index and address/data mux live in the top module.

## Test plan
(PAUSE_CYCLES=10 in simulation.)
- Single byte: base=0x50, n=1, dat[7:0]=0xA5, engine done after 20 cycles -> one start_write_sfp with addr 0x50 / byte 0xA5; sfp_wr_done exactly 11 cycles after entering WAIT.
- Full burst with wrap: base=0xFE, n=16, dat=0x0F0E..0100 -> 16 starts; addrs 0xFE, 0xFF, 0x00..0x0D; bytes 0x00..0x0F; one sfp_wr_done.
- Error mid-burst: n=4, i2c_error coincident with i2c_wr_done on byte 2 -> error_i2c_chip pulse, no sfp_wr_done, no byte-3 start, CS back to IDLE.
- Bad length: n=0, then n=17 -> error_bad_len pulse each time, zero start_write_sfp.
- Busy gating: i2c_lines_busy high in IDLE with start_sm held -> no LOAD until busy drops. Busy high at WAIT expiry -> next start is delayed until busy drops.
- Reset mid-WAIT of byte 3 of 8: reset_n low for 2 cycles -> CS=IDLE and all outputs 0; no further pulses until a new start_sm.

Source files
------------

// File: rtl/sfp_i2c_pkg.sv
// Shared definitions for the SFP/I2C register read and write machines.
package sfp_i2c_pkg;

   // Default device write-cycle pause: 5 ms at 125 MHz.
   localparam int unsigned SFP_PAUSE_CYCLES = 625000;
   // Largest burst carried by the 128-bit data port.
   localparam int unsigned SFP_MAX_BYTES    = 16;

   // Bit position of each state in the one-hot CS vector.
   localparam int unsigned IDX_IDLE          = 0;
   localparam int unsigned IDX_LOAD          = 1;
   localparam int unsigned IDX_START_WR_BYTE = 2;
   localparam int unsigned IDX_PAUSE_WR_BYTE = 3;
   localparam int unsigned IDX_WAIT          = 4;
   localparam int unsigned IDX_DONE          = 5;
   localparam int unsigned IDX_ERROR_I2C     = 6;
   localparam int unsigned IDX_ERROR_LEN     = 7;

   typedef enum logic [7:0] {
      StIdle        = 8'b0000_0001,
      StLoad        = 8'b0000_0010,
      StStartWrByte = 8'b0000_0100,
      StPauseWrByte = 8'b0000_1000,
      StWait        = 8'b0001_0000,
      StDone        = 8'b0010_0000,
      StErrorI2c    = 8'b0100_0000,
      StErrorLen    = 8'b1000_0000
   } sfp_state_e;

endpackage

// File: rtl/sfp_pause_timer.sv
// Loadable down-counter with zero flag; saturates at zero.
module sfp_pause_timer
   import sfp_i2c_pkg::*;
#(
   parameter int unsigned PAUSE_CYCLES = SFP_PAUSE_CYCLES
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_load,
   input  logic i_dec,
   output logic o_zero
);

   localparam int unsigned W = (PAUSE_CYCLES > 0) ? $clog2(PAUSE_CYCLES + 1) : 1;
   localparam logic [W-1:0] LP_RELOAD = W'(PAUSE_CYCLES);

   logic [W-1:0] r_count;

   // Reload on request, otherwise count down and hold at zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= LP_RELOAD;
      end else if (i_load) begin
         r_count <= LP_RELOAD;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/sfp_generic_write_sm.sv
// Burst register writer: sends up to 16 bytes to an SFP device through the
// shared I2C engine, one byte write at a time, pausing after each byte.
module sfp_generic_write_sm
   import sfp_i2c_pkg::*;
#(
   parameter int unsigned PAUSE_CYCLES = SFP_PAUSE_CYCLES,
   parameter int unsigned MAX_BYTES    = SFP_MAX_BYTES
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start_sm,
   input  logic         i2c_lines_busy,
   input  logic         i2c_error,
   input  logic         i2c_wr_done,
   input  logic [7:0]   wr_base_addr,
   input  logic [4:0]   wr_num_bytes,
   input  logic [127:0] wr_dat,
   output logic         start_write_sfp,
   output logic [7:0]   i2c_wr_addr,
   output logic [7:0]   i2c_wr_byte,
   output logic         sfp_wr_done,
   output logic         error_i2c_chip,
   output logic         error_bad_len,
   output logic         sm_running,
   output logic [7:0]   CS
);

   sfp_state_e     r_cs, w_ns;
   logic [7:0]     r_base;
   logic [4:0]     r_num;
   logic [127:0]   r_dat;
   logic [3:0]     r_k, w_k_nxt;
   logic [4:0]     w_k_inc;
   logic           w_more;
   logic           w_len_ok;
   logic           w_pause_zero;
   logic           w_timer_load;
   logic           w_timer_dec;

   logic           r_start_wr;
   logic           r_wr_done;
   logic           r_err_i2c;
   logic           r_err_len;
   logic           r_running;
   logic [7:0]     r_addr;
   logic [7:0]     r_byte;

   assign w_len_ok = (wr_num_bytes != 5'd0) && (wr_num_bytes <= 5'(MAX_BYTES));
   assign w_k_inc  = {1'b0, r_k} + 5'd1;
   assign w_more   = (w_k_inc < r_num);

   // Counter restarts on every entry to WAIT and runs only while in WAIT.
   assign w_timer_load = (w_ns == StWait) && (r_cs != StWait);
   assign w_timer_dec  = (r_cs == StWait);

   sfp_pause_timer #(
      .PAUSE_CYCLES (PAUSE_CYCLES)
   ) u_pause_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .i_load  (w_timer_load),
      .i_dec   (w_timer_dec),
      .o_zero  (w_pause_zero)
   );

   // Next-state and next byte index.
   always_comb begin
      w_ns    = r_cs;
      w_k_nxt = r_k;
      unique case (r_cs)
         StIdle: begin
            if (start_sm && !i2c_lines_busy) begin
               if (w_len_ok) begin
                  w_ns    = StLoad;
                  w_k_nxt = 4'd0;
               end else begin
                  w_ns = StErrorLen;
               end
            end
         end
         StLoad:        w_ns = StStartWrByte;
         StStartWrByte: w_ns = StPauseWrByte;
         StPauseWrByte: begin
            // An error reported with the done pulse still aborts the burst.
            if (i2c_error) begin
               w_ns = StErrorI2c;
            end else if (i2c_wr_done) begin
               w_ns = StWait;
            end
         end
         StWait: begin
            if (w_pause_zero && !i2c_lines_busy) begin
               if (w_more) begin
                  w_ns    = StStartWrByte;
                  w_k_nxt = w_k_inc[3:0];
               end else begin
                  w_ns = StDone;
               end
            end
         end
         StDone:     w_ns = StIdle;
         StErrorI2c: w_ns = StIdle;
         StErrorLen: w_ns = StIdle;
         default:    w_ns = StIdle;
      endcase
   end

   // State, byte index and burst parameters captured on entry to LOAD.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cs   <= StIdle;
         r_k    <= 4'd0;
         r_base <= 8'h00;
         r_num  <= 5'd0;
         r_dat  <= '0;
      end else begin
         r_cs <= w_ns;
         r_k  <= w_k_nxt;
         if (w_ns == StLoad) begin
            r_base <= wr_base_addr;
            r_num  <= wr_num_bytes;
            r_dat  <= wr_dat;
         end
      end
   end

   // Outputs registered from the next state so they line up with the state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_start_wr <= 1'b0;
         r_wr_done  <= 1'b0;
         r_err_i2c  <= 1'b0;
         r_err_len  <= 1'b0;
         r_running  <= 1'b0;
         r_addr     <= 8'h00;
         r_byte     <= 8'h00;
      end else begin
         r_start_wr <= (w_ns == StStartWrByte);
         r_wr_done  <= (w_ns == StDone);
         r_err_i2c  <= (w_ns == StErrorI2c);
         r_err_len  <= (w_ns == StErrorLen);
         r_running  <= (w_ns != StIdle);
         // Address/data only move when a new byte launches, so they stay
         // stable for the engine until the next start pulse.
         if (w_ns == StStartWrByte) begin
            r_addr <= r_base + {4'b0000, w_k_nxt};
            r_byte <= r_dat[{w_k_nxt, 3'b000} +: 8];
         end
      end
   end

   assign start_write_sfp = r_start_wr;
   assign sfp_wr_done     = r_wr_done;
   assign error_i2c_chip  = r_err_i2c;
   assign error_bad_len   = r_err_len;
   assign sm_running      = r_running;
   assign i2c_wr_addr     = r_addr;
   assign i2c_wr_byte     = r_byte;
   assign CS              = r_cs;

endmodule

// File: tb/tb_sfp_generic_write_sm.sv
// Directed bench for sfp_generic_write_sm with a small I2C engine model.
module tb_sfp_generic_write_sm;

   localparam int unsigned P = 10;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         start_sm;
   logic         i2c_lines_busy;
   logic         i2c_error;
   logic         i2c_wr_done;
   logic [7:0]   wr_base_addr;
   logic [4:0]   wr_num_bytes;
   logic [127:0] wr_dat;
   logic         start_write_sfp;
   logic [7:0]   i2c_wr_addr;
   logic [7:0]   i2c_wr_byte;
   logic         sfp_wr_done;
   logic         error_i2c_chip;
   logic         error_bad_len;
   logic         sm_running;
   logic [7:0]   CS;

   sfp_generic_write_sm #(
      .PAUSE_CYCLES (P),
      .MAX_BYTES    (16)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .start_sm        (start_sm),
      .i2c_lines_busy  (i2c_lines_busy),
      .i2c_error       (i2c_error),
      .i2c_wr_done     (i2c_wr_done),
      .wr_base_addr    (wr_base_addr),
      .wr_num_bytes    (wr_num_bytes),
      .wr_dat          (wr_dat),
      .start_write_sfp (start_write_sfp),
      .i2c_wr_addr     (i2c_wr_addr),
      .i2c_wr_byte     (i2c_wr_byte),
      .sfp_wr_done     (sfp_wr_done),
      .error_i2c_chip  (error_i2c_chip),
      .error_bad_len   (error_bad_len),
      .sm_running      (sm_running),
      .CS              (CS)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Monitor: counts pulses and logs launched address/data.
   int         n_starts = 0;
   int         n_done   = 0;
   int         n_err    = 0;
   int         n_bad    = 0;
   int         cyc      = 0;
   int         wait_cyc = 0;
   int         done_cyc = 0;
   logic [7:0] prev_cs  = 8'h00;
   logic [7:0] q_addr[$];
   logic [7:0] q_byte[$];

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (start_write_sfp === 1'b1) begin
            n_starts++;
            q_addr.push_back(i2c_wr_addr);
            q_byte.push_back(i2c_wr_byte);
         end
         if (sfp_wr_done === 1'b1) begin
            n_done++;
            done_cyc = cyc;
         end
         if (error_i2c_chip === 1'b1) n_err++;
         if (error_bad_len === 1'b1) n_bad++;
         if (CS == 8'h10 && prev_cs != 8'h10) wait_cyc = cyc;
         prev_cs = CS;
      end
   end

   // Engine model: done pulse eng_lat cycles after a start, with error on one address.
   int eng_lat      = 20;
   int eng_err_addr = -1;
   int eng_cnt      = 0;
   int eng_addr     = 0;

   initial begin
      i2c_wr_done = 1'b0;
      i2c_error   = 1'b0;
      forever begin
         @(negedge clk);
         i2c_wr_done = 1'b0;
         i2c_error   = 1'b0;
         if (reset_n !== 1'b1) begin
            eng_cnt = 0;
         end else if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
               i2c_wr_done = 1'b1;
               i2c_error   = (eng_addr == eng_err_addr);
            end
         end else if (start_write_sfp === 1'b1) begin
            eng_cnt  = eng_lat;
            eng_addr = int'(i2c_wr_addr);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic wait_end(input string tag, input int budget);
      int i = 0;
      while (!(CS == 8'h20 || CS == 8'h40 || CS == 8'h80) && i < budget) begin
         @(negedge clk);
         i++;
      end
      check_eq(tag, 32'(i < budget), 32'd1);
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic wait_cs(input string tag, input logic [7:0] st, input int budget);
      int i = 0;
      while (CS != st && i < budget) begin
         @(negedge clk);
         i++;
      end
      check_eq(tag, 32'(CS), 32'(st));
   endtask

   int s0, d0, e0, b0, qi;
   logic [7:0] ea;

   initial begin
      reset_n        = 1'b0;
      start_sm       = 1'b0;
      i2c_lines_busy = 1'b0;
      wr_base_addr   = 8'h00;
      wr_num_bytes   = 5'd0;
      wr_dat         = '0;
      repeat (3) @(negedge clk);

      // Reset state
      check_eq("rst_cs", 32'(CS), 32'h01);
      check_eq("rst_flags", 32'({start_write_sfp, sfp_wr_done, error_i2c_chip,
                                 error_bad_len, sm_running}), 32'h0);
      check_eq("rst_addr_byte", 32'({i2c_wr_addr, i2c_wr_byte}), 32'h0);
      reset_n = 1'b1;
      @(negedge clk);

      // Single byte, inputs scrambled after LOAD
      s0 = n_starts; d0 = n_done;
      wr_base_addr = 8'h50; wr_num_bytes = 5'd1; wr_dat = 128'hA5; eng_lat = 20;
      start_sm = 1'b1;
      @(negedge clk);
      check_eq("t1_load", 32'(CS), 32'h02);
      start_sm = 1'b0;
      wr_base_addr = 8'hEE; wr_num_bytes = 5'd3; wr_dat = {16{8'h3C}};
      @(negedge clk);
      check_eq("t1_start_cs", 32'(CS), 32'h04);
      check_eq("t1_start_pulse", 32'(start_write_sfp), 32'd1);
      check_eq("t1_addr", 32'(i2c_wr_addr), 32'h50);
      check_eq("t1_byte", 32'(i2c_wr_byte), 32'hA5);
      wait_end("t1_end", 200);
      check_eq("t1_starts", 32'(n_starts - s0), 32'd1);
      check_eq("t1_done", 32'(n_done - d0), 32'd1);
      check_eq("t1_pause", 32'(done_cyc - wait_cyc), 32'd11);
      check_eq("t1_idle", 32'(CS), 32'h01);

      // Full 16-byte burst with address wrap
      s0 = n_starts; d0 = n_done; e0 = n_err; qi = q_addr.size();
      wr_base_addr = 8'hFE; wr_num_bytes = 5'd16;
      wr_dat = 128'h0F0E0D0C0B0A09080706050403020100; eng_lat = 3;
      start_sm = 1'b1;
      @(negedge clk);
      start_sm = 1'b0;
      wait_end("t2_end", 2000);
      check_eq("t2_starts", 32'(n_starts - s0), 32'd16);
      check_eq("t2_done", 32'(n_done - d0), 32'd1);
      check_eq("t2_noerr", 32'(n_err - e0), 32'd0);
      for (int i = 0; i < 16; i++) begin
         if (qi + i < q_addr.size()) begin
            ea = 8'hFE + 8'(i);
            check_eq($sformatf("t2_addr%0d", i), 32'(q_addr[qi+i]), 32'(ea));
            check_eq($sformatf("t2_byte%0d", i), 32'(q_byte[qi+i]), 32'(i));
         end
      end

      // Error on the second byte of four
      s0 = n_starts; d0 = n_done; e0 = n_err;
      wr_base_addr = 8'h10; wr_num_bytes = 5'd4; wr_dat = 128'h44332211;
      eng_lat = 5; eng_err_addr = 32'h11;
      start_sm = 1'b1;
      @(negedge clk);
      start_sm = 1'b0;
      wait_end("t3_end", 1000);
      eng_err_addr = -1;
      check_eq("t3_err", 32'(n_err - e0), 32'd1);
      check_eq("t3_nodone", 32'(n_done - d0), 32'd0);
      check_eq("t3_starts", 32'(n_starts - s0), 32'd2);
      check_eq("t3_idle", 32'(CS), 32'h01);

      // Illegal lengths 0 and 17
      s0 = n_starts; b0 = n_bad;
      wr_num_bytes = 5'd0; start_sm = 1'b1;
      @(negedge clk);
      check_eq("t4_len0_cs", 32'(CS), 32'h80);
      check_eq("t4_len0_pulse", 32'(error_bad_len), 32'd1);
      start_sm = 1'b0;
      @(negedge clk);
      check_eq("t4_len0_idle", 32'(CS), 32'h01);
      wr_num_bytes = 5'd17; start_sm = 1'b1;
      @(negedge clk);
      check_eq("t4_len17_cs", 32'(CS), 32'h80);
      start_sm = 1'b0;
      @(negedge clk);
      check_eq("t4_len17_running", 32'(sm_running), 32'd0);
      @(negedge clk);
      check_eq("t4_bad", 32'(n_bad - b0), 32'd2);
      check_eq("t4_starts", 32'(n_starts - s0), 32'd0);

      // Busy gating in IDLE and at WAIT expiry
      s0 = n_starts; d0 = n_done;
      wr_base_addr = 8'h20; wr_num_bytes = 5'd2; wr_dat = 128'hBBAA; eng_lat = 3;
      i2c_lines_busy = 1'b1; start_sm = 1'b1;
      repeat (5) @(negedge clk);
      check_eq("t5_idle_busy", 32'(CS), 32'h01);
      check_eq("t5_idle_run", 32'(sm_running), 32'd0);
      i2c_lines_busy = 1'b0;
      @(negedge clk);
      check_eq("t5_load", 32'(CS), 32'h02);
      start_sm = 1'b0;
      wait_cs("t5_wait", 8'h10, 200);
      i2c_lines_busy = 1'b1;
      repeat (15) @(negedge clk);
      check_eq("t5_wait_held", 32'(CS), 32'h10);
      check_eq("t5_one_start", 32'(n_starts - s0), 32'd1);
      i2c_lines_busy = 1'b0;
      @(negedge clk);
      check_eq("t5_restart_cs", 32'(CS), 32'h04);
      check_eq("t5_restart_pulse", 32'(start_write_sfp), 32'd1);
      check_eq("t5_addr2", 32'(i2c_wr_addr), 32'h21);
      check_eq("t5_byte2", 32'(i2c_wr_byte), 32'hBB);
      wait_end("t5_end", 500);
      check_eq("t5_done", 32'(n_done - d0), 32'd1);

      // Reset during WAIT of byte 3 of 8
      s0 = n_starts; d0 = n_done;
      wr_base_addr = 8'h30; wr_num_bytes = 5'd8; wr_dat = 128'h8877665544332211; eng_lat = 2;
      start_sm = 1'b1;
      @(negedge clk);
      start_sm = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         if ((n_starts - s0) == 3 && CS == 8'h10) break;
         @(negedge clk);
      end
      check_eq("t6_reach_wait3", 32'(CS), 32'h10);
      repeat (3) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_eq("t6_rst_cs", 32'(CS), 32'h01);
      check_eq("t6_rst_flags", 32'({start_write_sfp, sfp_wr_done, error_i2c_chip,
                                    error_bad_len, sm_running}), 32'h0);
      check_eq("t6_rst_addr_byte", 32'({i2c_wr_addr, i2c_wr_byte}), 32'h0);
      reset_n = 1'b1;
      repeat (40) @(negedge clk);
      check_eq("t6_starts", 32'(n_starts - s0), 32'd3);
      check_eq("t6_nodone", 32'(n_done - d0), 32'd0);
      check_eq("t6_idle", 32'(CS), 32'h01);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
